clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Controller for the team's even-ratio counter clock divider: owns the half-period setting and run/stop sequencing, and generates the divided clock.
- Reconfiguration is glitch-free: a new ratio takes effect only at a clk_out falling boundary.
- Stops are glitch-free: clk_out always parks low and no high pulse is ever truncated.
- Sits between a register/config master (valid/ready) and logic clocked or enabled by clk_out.

Parameters:
- CNT_W, 8, width of the half-period counter and of the cfg_half field.
- DEF_HALF, 4, reset half-period in clk_in cycles (divide ratio = 2*half, so the default is divide-by-8); must be >= 1.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- run_en  input  1  level; 1 = run divider, 0 = stop cleanly.
- cfg_valid  input  1  new half-period offered.
- cfg_half  input  CNT_W  requested half-period in clk_in cycles.
- cfg_ready  output  1  1 = no config pending; accept when cfg_valid & cfg_ready.
- cfg_err  output  1  1-cycle pulse: accepted cfg_half was 0 and was discarded.
- clk_out  output  1  divided clock, registered.
- tick_rise  output  1  1-cycle pulse, high in the same cycle clk_out first reads 1.
- busy  output  1  1 when state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, clk_out=0, cnt=0, half_q=DEF_HALF, pend_q=0, cfg_ready=1, cfg_err=0, tick_rise=0. Reset during any operation aborts immediately and discards any pending config.
- States:
  - IDLE: cnt held at 0, clk_out=0.
  - RUN: divider running.
  - STOP: finishing the current high phase before parking.
- Counting in RUN and STOP:
  - If cnt == half_q-1: toggle clk_out and set cnt=0.
  - Otherwise: cnt+1.
  - half_q=1 gives divide-by-2.
- Fall boundary: the edge where clk_out toggles 1->0.
- Rise: the edge where clk_out toggles 0->1; tick_rise=1 for exactly that following cycle.
- Transitions:
  - IDLE->RUN when run_en=1; cnt starts at 0, so the first rise occurs half_q edges after entry.
  - RUN->IDLE when run_en=0 and clk_out=0; this may truncate a low phase, which is allowed.
  - RUN->STOP when run_en=0 and clk_out=1.
  - STOP->IDLE at the fall boundary. run_en is ignored in STOP.
  - IDLE re-enters RUN on the next edge if run_en=1, so the minimum stop is one IDLE cycle.
- Config handshake:
  - cfg_ready = ~pend_q.
  - On accept with cfg_half != 0: pend_half=cfg_half, pend_q=1.
  - On accept with cfg_half == 0: nothing is stored, and cfg_err=1 on the next cycle.
- Applying a pending config:
  - In IDLE: half_q=pend_half and pend_q=0 one edge after acceptance.
  - In RUN/STOP: applied only at a fall boundary, in the same edge as the toggle. cnt=0, so the next low phase already uses the new half.
  - A config accepted in the same edge as a boundary is not applied at that boundary; it waits for the next one.
  - Applying a config and a state change at the same edge are independent; both happen.
- No combinational path from inputs to outputs except cfg_ready, which is pend_q only.

Optional Feature:
- Macro: CLK_DIV_CTRL_PCNT_EN.
- Defined: adds output pcnt [15:0].
  - Increments at each fall boundary and wraps 16'hFFFF->0.
  - Reset value 0; cleared to 0 at every edge where a config is applied (the clear overrides the increment).
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run_en=1 held, defaults: clk_out rises 4 edges after RUN entry, then 4 high / 4 low with period 8. tick_rise is high for exactly 1 cycle per period, aligned with the clk_out rise. busy=1.
- While running at half=4, offer cfg_half=2 mid high phase: cfg_ready drops the cycle after accept. Current period completes as 4H/4L-boundary, then 2H/2L follows. cfg_ready returns to 1 after the boundary. No clk_out pulse shorter than 2 cycles.
- Drop run_en 1 cycle after a rise (half=4): state goes to STOP, clk_out stays high the full 4 cycles, falls, state=IDLE, busy=0, clk_out stays 0.
- Drop run_en in a low phase: next edge state=IDLE, clk_out=0, with no high pulse emitted.
- In IDLE, accept cfg_half=0: cfg_err pulses 1 cycle, half_q stays at 4, cfg_ready stays 1. Then accept cfg_half=1 and run: clk_out toggles every cycle (divide-by-2).
- Assert rst mid high phase with a config pending: next cycle clk_out=0, IDLE, cfg_ready=1, half_q=4. With CLK_DIV_CTRL_PCNT_EN, pcnt=0, and after 3 full periods pcnt=3.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Even-ratio clock divider controller: glitch-free ratio reconfiguration and run/stop sequencing.
// Optional pulse counter output pcnt is built when CLK_DIV_CTRL_PCNT_EN is defined.
module clk_div_ctrl #(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             busy,
`ifdef CLK_DIV_CTRL_PCNT_EN
    output logic [15:0]      pcnt,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             err_q, err_d;
    logic             tick_q, tick_d;
`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0]      pcnt_q, pcnt_d;
`endif

    logic accept;
    logic at_term;
    logic fall;
    logic rise;
    logic apply;

    // Config handshake: a transfer happens on an edge where cfg_valid & cfg_ready;
    // cfg_ready is low exactly while an accepted ratio waits for its apply point.
    always_comb begin
        accept  = cfg_valid & ~pend_q;
        at_term = (cnt_q == half_q - ONE);
        fall    = (state_q != IDLE) & at_term & clk_q;
        rise    = (state_q == RUN) & run_en & at_term & ~clk_q;
        apply   = pend_q & ((state_q == IDLE) | fall);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clk_d       = clk_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;
        err_d       = 1'b0;
        tick_d      = rise;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (run_en) state_d = RUN;
            end
            RUN: begin
                if (!run_en && !clk_q) begin
                    // Truncating a low phase is safe; no rise is allowed to escape here.
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    if (at_term) begin
                        cnt_d = '0;
                        clk_d = ~clk_q;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    if (!run_en) state_d = fall ? IDLE : STOP;
                end
            end
            STOP: begin
                if (at_term) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                if (fall) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        if (accept) begin
            if (cfg_half != '0) begin
                pend_half_d = cfg_half;
                pend_d      = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // A config accepted on this edge has pend_q=0, so it can only apply at a later boundary.
        if (apply) begin
            half_d = pend_half_q;
            pend_d = 1'b0;
        end
    end

`ifdef CLK_DIV_CTRL_PCNT_EN
    always_comb begin
        pcnt_d = pcnt_q;
        if (apply) begin
            pcnt_d = '0;
        end else if (fall) begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign pcnt = pcnt_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= DEF_HALF_V;
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            err_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            err_q       <= err_d;
            tick_q      <= tick_d;
        end
    end

    assign cfg_ready = ~pend_q;
    assign cfg_err   = err_q;
    assign clk_out   = clk_q;
    assign tick_rise = tick_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: run/stop sequencing, ratio changes, config errors and reset abort.
module tb_clk_div_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       run_en;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick_rise;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0] pcnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    // Expected {tick_rise, clk_out} per cycle
    logic [1:0] exp_q[$];

    clk_div_ctrl #(.CNT_W(8), .DEF_HALF(4)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .busy      (busy),
`ifdef CLK_DIV_CTRL_PCNT_EN
        .pcnt      (pcnt),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Waveform for edges first..last after an origin edge where cnt=0 and clk_out=0.
    task automatic push_div(input int half, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({((i % (2 * half)) == half) ? 1'b1 : 1'b0,
                             ((i / half) % 2 == 1) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic drain(input string tag);
        logic [1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            check({tag, "_clk"}, clk_out, e[0]);
            check({tag, "_tick"}, tick_rise, e[1]);
        end
    endtask

    task automatic send_cfg(input logic [7:0] h);
        cfg_valid = 1'b1;
        cfg_half  = h;
        step();
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
    endtask

    initial begin
        rst       = 1'b1;
        run_en    = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        step();
        check("rst_clk", clk_out, 1'b0);
        check("rst_state", dbg_state, S_IDLE);
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_err", cfg_err, 1'b0);
        check("rst_tick", tick_rise, 1'b0);
        check("rst_busy", busy, 1'b0);
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("rst_pcnt", pcnt, 16'd0);
`endif

        // Default divide-by-8: rise 4 edges after RUN entry
        rst    = 1'b0;
        run_en = 1'b1;
        step();
        check("run_state", dbg_state, S_RUN);
        check("run_busy", busy, 1'b1);
        check("run_clk0", clk_out, 1'b0);
        push_div(4, 1, 21);
        drain("div8");
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("pcnt_two", pcnt, 16'd2);
`endif

        // Ratio change to 2 offered mid high phase; applies at the next fall
        send_cfg(8'd2);
        check("cfg_ready_low", cfg_ready, 1'b0);
        check("cfg_hold_clk", clk_out, 1'b1);
        step();
        check("cfg_ready_low2", cfg_ready, 1'b0);
        check("cfg_hold_clk2", clk_out, 1'b1);
        step();
        check("cfg_fall_clk", clk_out, 1'b0);
        check("cfg_ready_back", cfg_ready, 1'b1);
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("pcnt_cleared", pcnt, 16'd0);
`endif
        push_div(2, 1, 5);
        drain("div4");
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("pcnt_one", pcnt, 16'd1);
`endif

        // Stop in a low phase on the edge that would otherwise rise
        run_en = 1'b0;
        step();
        check("lowstop_state", dbg_state, S_IDLE);
        check("lowstop_clk", clk_out, 1'b0);
        check("lowstop_tick", tick_rise, 1'b0);
        check("lowstop_busy", busy, 1'b0);
        step();
        check("lowstop_clk2", clk_out, 1'b0);

        // Restore half=4 in IDLE: applied one edge after accept
        send_cfg(8'd4);
        check("idle_cfg_ready0", cfg_ready, 1'b0);
        step();
        check("idle_cfg_ready1", cfg_ready, 1'b1);

        // Zero half is rejected
        send_cfg(8'd0);
        check("zero_err", cfg_err, 1'b1);
        check("zero_ready", cfg_ready, 1'b1);
        step();
        check("zero_err_clr", cfg_err, 1'b0);
        check("zero_ready2", cfg_ready, 1'b1);

        // Run at half=4 (proves the zero was discarded), stop one cycle after rise
        run_en = 1'b1;
        step();
        check("r2_state", dbg_state, S_RUN);
        push_div(4, 1, 4);
        drain("r2");
        run_en = 1'b0;
        step();
        check("stop_state", dbg_state, S_STOP);
        check("stop_clk", clk_out, 1'b1);
        check("stop_busy", busy, 1'b1);
        check("stop_tick", tick_rise, 1'b0);
        step();
        check("stop_clk2", clk_out, 1'b1);
        step();
        check("stop_clk3", clk_out, 1'b1);
        check("stop_state3", dbg_state, S_STOP);
        step();
        check("park_clk", clk_out, 1'b0);
        check("park_state", dbg_state, S_IDLE);
        check("park_busy", busy, 1'b0);
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("park_pcnt", pcnt, 16'd1);
`endif
        step();
        check("park_clk2", clk_out, 1'b0);
        check("park_tick2", tick_rise, 1'b0);

        // Divide-by-2
        send_cfg(8'd1);
        step();
        check("div2_ready", cfg_ready, 1'b1);
        run_en = 1'b1;
        step();
        check("div2_state", dbg_state, S_RUN);
        push_div(1, 1, 3);
        drain("div2");

        // Config accepted on a fall edge waits; reset then discards it
        cfg_valid = 1'b1;
        cfg_half  = 8'd3;
        step();
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        check("same_edge_clk", clk_out, 1'b0);
        check("same_edge_ready", cfg_ready, 1'b0);
        step();
        check("pend_clk_high", clk_out, 1'b1);
        check("pend_ready", cfg_ready, 1'b0);
        rst = 1'b1;
        step();
        check("abort_clk", clk_out, 1'b0);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_ready", cfg_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_tick", tick_rise, 1'b0);
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("abort_pcnt", pcnt, 16'd0);
`endif

        // After reset the ratio is back to the default of 4
        rst = 1'b0;
        step();
        check("post_rst_state", dbg_state, S_RUN);
        push_div(4, 1, 24);
        drain("post_rst");
`ifdef CLK_DIV_CTRL_PCNT_EN
        check("pcnt_three", pcnt, 16'd3);
`endif
        run_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
